// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath defaults and write-back FSM encoding.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/etapa_escritura.sv
// Write-back stage: retires ALU results directly and waits (bounded) for load data
// before strobing the register bank.
module etapa_escritura
    import mips_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              Regwrite,
    output logic              timeout_err,
    output logic [15:0]       retire_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    wb_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              to_q, to_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              accept;

    assign in_ready = (state_q != WAIT_MEM) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dest_d  = dest_q;
        rw_d    = rw_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            WAIT_MEM: begin
                // flush beats a same-cycle response; a response beats expiry
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rvalid) begin
                    state_d = WRITE;
                    if (rw_q && dest_q != '0) begin
                        wen_d   = 1'b1;
                        wreg_d  = dest_q;
                        wdata_d = mem_rdata;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    dest_d = in_dest;
                    rw_d   = in_regwrite;
                    if (in_memtoreg) begin
                        state_d = WAIT_MEM;
                        timer_d = '0;
                    end else begin
                        state_d = WRITE;
                        if (in_regwrite && in_dest != '0) begin
                            wen_d   = 1'b1;
                            wreg_d  = in_dest;
                            wdata_d = in_alu_result;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        cnt_d = cnt_q + 16'(wen_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            dest_q  <= '0;
            rw_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dest_q  <= dest_d;
            rw_q    <= rw_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign WriteReg     = wreg_q;
    assign WriteData    = wdata_q;
    assign Regwrite     = wen_q;
    assign timeout_err  = to_q;
    assign retire_count = cnt_q;

endmodule
